// File: rtl/seq_s_rbs16.sv
// seq_s_rbs16: multi-cycle signed ripple-borrow subtractor, out = a - b.
//   Computes an exact (N+1)-bit two's-complement difference, CHUNK bits per
//   clock, LSB chunk first. The subtraction is done as a + ~b + 1, with a
//   single carry register threaded between chunks. Valid/ready handshake
//   on both the operand and result sides.
// Optional feature macro: SEQ_RBS_OVF_EN adds the ovf port, which flags that
//   the N-bit truncated result would have overflowed.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operands a, b present
//   in_ready   block can accept operands (IDLE)
//   a, b       N-bit signed minuend / subtrahend, sampled on the accept edge
//   out_valid  result valid, held until consumed
//   out_ready  consumer accepts result
//   out        (N+1)-bit signed difference
//   ovf        (SEQ_RBS_OVF_EN only) N-bit overflow flag
module seq_s_rbs16 #(
    parameter int unsigned N     = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   out
`ifdef SEQ_RBS_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int unsigned K     = N / CHUNK;
    localparam int unsigned IDX_W = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [N-1:0]       a_q;
    logic [N-1:0]       nb_q;
    logic               carry;
    logic [IDX_W-1:0]   idx;

    int unsigned        base;
    logic [CHUNK-1:0]   a_chunk;
    logic [CHUNK-1:0]   nb_chunk;
    logic [CHUNK:0]     sum;
    logic               last;
    logic               top;

    // One chunk of a + ~b + carry, plus the sign-extended top bit
    always_comb begin
        base     = 32'(idx) * CHUNK;
        a_chunk  = a_q[base +: CHUNK];
        nb_chunk = nb_q[base +: CHUNK];
        sum      = {1'b0, a_chunk} + {1'b0, nb_chunk} + {{CHUNK{1'b0}}, carry};
        last     = (idx == IDX_W'(K - 1));
        // Bit N of the exact result: both operands sign-extended one bit,
        // plus the carry out of bit N-1.
        top      = a_q[N-1] ^ nb_q[N-1] ^ sum[CHUNK];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = CALC;
            CALC:    if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Datapath and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            nb_q      <= '0;
            carry     <= 1'b1;
            idx       <= '0;
            out       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
`ifdef SEQ_RBS_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        nb_q  <= ~b;
                        carry <= 1'b1;      // the +1 of two's-complement negation
                        idx   <= '0;
                    end
                end
                CALC: begin
                    out[base +: CHUNK] <= sum[CHUNK-1:0];
                    carry              <= sum[CHUNK];
                    idx                <= idx + IDX_W'(1);
                    if (last) begin
                        out[N] <= top;
`ifdef SEQ_RBS_OVF_EN
                        // Sign bit differs from bit N-1: N-bit result would wrap
                        ovf    <= top ^ sum[CHUNK-1];
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
